// File: rtl/bfp_shift_planner_pkg.sv
// Shared definitions for the block-floating-point shift planner and its leading-sign counter.
package bfp_shift_planner_pkg;

    localparam int DW_DEF   = 10;
    localparam int SMAX_DEF = 7;
    localparam int NLANE    = 8;
    localparam int RSBW     = 4;

    localparam logic [1:0] ST_COLLECT = 2'd0;
    localparam logic [1:0] ST_CALC    = 2'd1;
    localparam logic [1:0] ST_HOLD    = 2'd2;

    // Field order matches the shifter bank control word {x, s2, s1, s0}.
    typedef struct packed {
        logic       x;
        logic [2:0] amt;
    } shift_code_t;

    function automatic logic [2:0] clamp_shift(input logic [RSBW-1:0] r, input logic [RSBW-1:0] lim);
        return (r > lim) ? lim[2:0] : r[2:0];
    endfunction

endpackage

// File: rtl/lsc_count.sv
// Leading-sign counter: number of bits below the MSB that repeat the sign bit.
// Latency: combinational. Backpressure: none.
// Returns DW-1 for both 0 and -1; reused by the error-normalisation path.
module lsc_count
    import bfp_shift_planner_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic [DW-1:0]   val,
    output logic [RSBW-1:0] rsb
);

    logic run;

    always_comb begin
        rsb = '0;
        run = 1'b1;
        for (int i = DW - 2; i >= 0; i--) begin
            if (run && (val[i] == val[DW-1])) begin
                rsb = rsb + RSBW'(1);
            end else begin
                run = 1'b0;
            end
        end
    end

endmodule

// File: rtl/bfp_shift_planner.sv
// Collects 8 samples and emits them with the common normalising left shift.
// Latency: out_valid rises two edges after the edge accepting the 8th sample.
// Backpressure: result held until out_ready; din_ready low from CALC until then.
module bfp_shift_planner
    import bfp_shift_planner_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int SMAX = SMAX_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] din,
    input  logic          din_valid,
    output logic          din_ready,
    output logic [DW-1:0] A1,
    output logic [DW-1:0] A2,
    output logic [DW-1:0] A3,
    output logic [DW-1:0] A4,
    output logic [DW-1:0] A5,
    output logic [DW-1:0] A6,
    output logic [DW-1:0] A7,
    output logic [DW-1:0] A8,
    output logic          s0,
    output logic          s1,
    output logic          s2,
    output logic          x,
    output logic          zero_blk,
    output logic          out_valid,
    input  logic          out_ready
);

    localparam logic [RSBW-1:0] RSB_INIT = RSBW'(DW - 1);
    localparam logic [RSBW-1:0] SMAX_W   = RSBW'(SMAX);
    localparam logic [2:0]      LAST     = 3'(NLANE - 1);

    logic [1:0]      state;
    logic [2:0]      cnt;
    logic [DW-1:0]   lane [NLANE];
    logic [RSBW-1:0] min_rsb;
    logic [RSBW-1:0] din_rsb;
    logic            allz;
    shift_code_t     code;
    shift_code_t     calc_code;
    logic            zero_q;
    logic            valid_q;
    logic            accept;
    logic            din_zero;

    lsc_count #(.DW(DW)) u_lsc (
        .val (din),
        .rsb (din_rsb)
    );

    assign din_ready = (state == ST_COLLECT);
    assign accept    = din_valid && din_ready;
    assign din_zero  = (din == '0);

    always_comb begin
        calc_code     = '0;
        calc_code.amt = allz ? 3'd0 : clamp_shift(min_rsb, SMAX_W);
        calc_code.x   = (calc_code.amt != 3'd0);
    end

    // Lanes are only overwritten on accept; nothing clears them between blocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NLANE; i++) begin
                lane[i] <= '0;
            end
        end else if (accept) begin
            lane[cnt] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_COLLECT;
            cnt     <= '0;
            min_rsb <= RSB_INIT;
            allz    <= 1'b1;
            code    <= '0;
            zero_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                ST_COLLECT: begin
                    if (accept) begin
                        cnt     <= cnt + 3'd1;
                        min_rsb <= ((cnt == 3'd0) || (din_rsb < min_rsb)) ? din_rsb : min_rsb;
                        allz    <= ((cnt == 3'd0) | allz) & din_zero;
                        if (cnt == LAST) begin
                            state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    code   <= calc_code;
                    zero_q <= allz;
                    state  <= ST_HOLD;
                end
                ST_HOLD: begin
                    // out_valid is raised one cycle into HOLD, giving the two-edge latency.
                    if (!valid_q) begin
                        valid_q <= 1'b1;
                    end else if (out_ready) begin
                        valid_q <= 1'b0;
                        state   <= ST_COLLECT;
                        min_rsb <= RSB_INIT;
                        allz    <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_COLLECT;
                end
            endcase
        end
    end

    assign A1 = lane[0];
    assign A2 = lane[1];
    assign A3 = lane[2];
    assign A4 = lane[3];
    assign A5 = lane[4];
    assign A6 = lane[5];
    assign A7 = lane[6];
    assign A8 = lane[7];

    assign {x, s2, s1, s0} = code;
    assign zero_blk        = zero_q;
    assign out_valid       = valid_q;

endmodule

// File: tb/tb_bfp_shift_planner.sv
// Randomised and directed checks of bfp_shift_planner against a range-based rsb model.
module tb_bfp_shift_planner;

    typedef logic signed [9:0] smp_t;
    typedef smp_t blk_t [8];

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] din;
    logic       din_valid;
    logic       din_ready;
    logic [9:0] A1, A2, A3, A4, A5, A6, A7, A8;
    logic       s0, s1, s2, x, zero_blk, out_valid, out_ready;
    logic [9:0] a_out [8];

    int n_tests = 0;
    int n_fail  = 0;

    bfp_shift_planner dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .A1        (A1),
        .A2        (A2),
        .A3        (A3),
        .A4        (A4),
        .A5        (A5),
        .A6        (A6),
        .A7        (A7),
        .A8        (A8),
        .s0        (s0),
        .s1        (s1),
        .s2        (s2),
        .x         (x),
        .zero_blk  (zero_blk),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    assign a_out[0] = A1;
    assign a_out[1] = A2;
    assign a_out[2] = A3;
    assign a_out[3] = A4;
    assign a_out[4] = A5;
    assign a_out[5] = A6;
    assign a_out[6] = A7;
    assign a_out[7] = A8;

    // rsb(v) is the largest r such that v fits in a (10-r)-bit signed field.
    function automatic int rsb_model(input smp_t v);
        int r  = 0;
        int vi = int'(v);
        for (int k = 0; k < 10; k++) begin
            if (vi >= -(1 << (9 - k)) && vi < (1 << (9 - k))) r = k;
        end
        return r;
    endfunction

    function automatic bit all_zero(input blk_t b);
        bit z = 1'b1;
        for (int k = 0; k < 8; k++) if (b[k] != 0) z = 1'b0;
        return z;
    endfunction

    function automatic int exp_shift(input blk_t b);
        int m = 9;
        for (int k = 0; k < 8; k++) if (rsb_model(b[k]) < m) m = rsb_model(b[k]);
        if (all_zero(b)) return 0;
        return (m > 7) ? 7 : m;
    endfunction

    function automatic smp_t rand_smp();
        smp_t r;
        r = smp_t'($urandom);
        return r >>> $urandom_range(0, 9);
    endfunction

    // Drives one block (optionally with idle gaps) and measures edges from the 8th accept to out_valid.
    task automatic feed_block(input blk_t b, input bit gaps, output int lat);
        int i = 0;
        int guard = 0;
        bit rdy;
        lat = 99;
        while (i < 8 && guard < 400) begin
            @(negedge clk);
            rdy       = din_ready;
            din       = b[i];
            din_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            @(posedge clk);
            if (din_valid && rdy) i++;
            guard++;
        end
        if (i == 8) begin
            lat = 0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                din_valid = 1'b0;
                if (out_valid) break;
                @(posedge clk);
                lat++;
            end
        end
        din_valid = 1'b0;
    endtask

    task automatic release_block();
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; din = '0; din_valid = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++; if (din_ready !== 1'b1) begin n_fail++; $display("FAIL reset_din_ready got=%b want=1", din_ready); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        n_tests++; if ({x, s2, s1, s0, zero_blk} !== 5'b0) begin n_fail++; $display("FAIL reset_code got=%b want=00000", {x, s2, s1, s0, zero_blk}); end
        for (int k = 0; k < 8; k++) begin
            n_tests++; if (a_out[k] !== 10'd0) begin n_fail++; $display("FAIL reset_lane%0d got=%0d want=0", k, a_out[k]); end
        end
    endtask

    task automatic test_directed();
        blk_t vec [4];
        int lat, es;
        vec[0] = '{10'sd3, -10'sd4, 10'sd100, 10'sd0, 10'sd0, 10'sd0, 10'sd0, 10'sd0};
        vec[3] = '{10'sd511, -10'sd512, 10'sd1, 10'sd1, 10'sd1, 10'sd1, 10'sd1, 10'sd1};
        for (int k = 0; k < 8; k++) begin
            vec[1][k] = 10'sd0;
            vec[2][k] = -10'sd1;
        end
        for (int v = 0; v < 4; v++) begin
            feed_block(vec[v], 1'b0, lat);
            es = exp_shift(vec[v]);
            n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL dir%0d_latency got=%0d want=2", v, lat); end
            for (int k = 0; k < 8; k++) begin
                n_tests++; if (a_out[k] !== vec[v][k]) begin n_fail++; $display("FAIL dir%0d_lane%0d got=%0d want=%0d", v, k, a_out[k], vec[v][k]); end
            end
            n_tests++; if ({s2, s1, s0} !== 3'(es)) begin n_fail++; $display("FAIL dir%0d_shift got=%0d want=%0d", v, {s2, s1, s0}, es); end
            n_tests++; if (x !== (es != 0)) begin n_fail++; $display("FAIL dir%0d_x got=%b want=%b", v, x, es != 0); end
            n_tests++; if (zero_blk !== all_zero(vec[v])) begin n_fail++; $display("FAIL dir%0d_zero_blk got=%b want=%b", v, zero_blk, all_zero(vec[v])); end
            release_block();
        end
    endtask

    task automatic test_random();
        blk_t b;
        int lat, es;
        for (int n = 0; n < 12; n++) begin
            for (int k = 0; k < 8; k++) b[k] = ($urandom_range(0, 4) == 0) ? smp_t'(0) : rand_smp();
            feed_block(b, 1'b1, lat);
            es = exp_shift(b);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            n_tests++; if (lat !== 2 || out_valid !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_valid lat=%0d ov=%b want lat=2 ov=1", n, lat, out_valid); end
            for (int k = 0; k < 8; k++) begin
                n_tests++; if (a_out[k] !== b[k]) begin n_fail++; $display("FAIL rnd%0d_lane%0d got=%0d want=%0d", n, k, a_out[k], b[k]); end
            end
            n_tests++; if ({x, s2, s1, s0} !== {es != 0, 3'(es)}) begin n_fail++; $display("FAIL rnd%0d_code got=%b want=%b", n, {x, s2, s1, s0}, {es != 0, 3'(es)}); end
            n_tests++; if (zero_blk !== all_zero(b)) begin n_fail++; $display("FAIL rnd%0d_zero_blk got=%b want=%b", n, zero_blk, all_zero(b)); end
            release_block();
            n_tests++; if (din_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_release rdy=%b ov=%b want rdy=1 ov=0", n, din_ready, out_valid); end
        end
    endtask

    task automatic test_backpressure();
        blk_t b1, b2;
        int lat;
        b1 = '{10'sd300, 10'sd7, -10'sd9, 10'sd2, 10'sd0, 10'sd1, -10'sd1, 10'sd5};
        b2 = '{10'sd20, -10'sd3, 10'sd5, 10'sd0, 10'sd0, 10'sd0, 10'sd0, 10'sd0};
        feed_block(b1, 1'b1, lat);
        n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL bp_latency got=%0d want=2", lat); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            din       = 10'h155;
            din_valid = 1'b1;
            n_tests++; if (out_valid !== 1'b1 || din_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold%0d ov=%b rdy=%b want ov=1 rdy=0", c, out_valid, din_ready); end
            n_tests++; if ({x, s2, s1, s0, zero_blk} !== 5'b0 || A1 !== 10'd300 || A8 !== 10'd5) begin n_fail++; $display("FAIL bp_stable%0d code=%b A1=%0d A8=%0d want 00000/300/5", c, {x, s2, s1, s0, zero_blk}, A1, A8); end
        end
        @(negedge clk);
        din_valid = 1'b0;
        release_block();
        n_tests++; if (din_ready !== 1'b1) begin n_fail++; $display("FAIL bp_din_ready_after got=%b want=1", din_ready); end
        feed_block(b2, 1'b0, lat);
        n_tests++; if ({x, s2, s1, s0} !== 4'b1100 || zero_blk !== 1'b0) begin n_fail++; $display("FAIL bp_second_block code=%b zb=%b want 1100/0", {x, s2, s1, s0}, zero_blk); end
        n_tests++; if (A1 !== 10'd20 || A4 !== 10'd0) begin n_fail++; $display("FAIL bp_second_lanes A1=%0d A4=%0d want 20/0", A1, A4); end
        release_block();
    endtask

    task automatic test_mid_reset();
        blk_t ones;
        int lat, acc;
        acc = 0;
        for (int g = 0; g < 50 && acc < 4; g++) begin
            @(negedge clk);
            din = 10'd200; din_valid = 1'b1;
            @(posedge clk);
            acc++;
        end
        @(negedge clk);
        din_valid = 1'b0;
        n_tests++; if (A1 !== 10'd200 || A4 !== 10'd200) begin n_fail++; $display("FAIL mrst_pre A1=%0d A4=%0d want 200/200", A1, A4); end
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if (A1 !== 10'd0 || A4 !== 10'd0) begin n_fail++; $display("FAIL mrst_lanes A1=%0d A4=%0d want 0/0", A1, A4); end
        n_tests++; if ({x, s2, s1, s0, zero_blk, out_valid} !== 6'b0 || din_ready !== 1'b1) begin n_fail++; $display("FAIL mrst_outs got=%b rdy=%b want 000000/1", {x, s2, s1, s0, zero_blk, out_valid}, din_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) ones[k] = 10'sd1;
        feed_block(ones, 1'b0, lat);
        n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL mrst_latency got=%0d want=2", lat); end
        n_tests++; if ({x, s2, s1, s0, zero_blk} !== 5'b11110) begin n_fail++; $display("FAIL mrst_code got=%b want=11110", {x, s2, s1, s0, zero_blk}); end
        n_tests++; if (A1 !== 10'd1 || A8 !== 10'd1) begin n_fail++; $display("FAIL mrst_fresh_lanes A1=%0d A8=%0d want 1/1", A1, A8); end
        release_block();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
